data_mem_responder: RTL and testbench

- Responder side of the pipeline's MEM-stage data-memory interface. Accepts the sized read/write requests the EX-MEM register drives and performs them after a parameterised wait.
- Drives `mem_stall` back to the hazard logic so the pipeline freezes while an access is outstanding.
- Holds the data RAM. Supports byte, halfword and word accesses, little-endian, with sign or zero extension on reads.

---
 rtl/data_mem_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the MEM-stage data-memory interface. Accepts a sized
// read or write request from the EX-MEM register, holds the pipeline with
// mem_stall while the access is outstanding, performs the access against the
// internal data RAM after LATENCY cycles, and pulses rvalid / wdone in the
// single DONE cycle that follows. Byte, halfword and word accesses are
// little-endian; byte/half loads are sign- or zero-extended.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   mem_read      read size  (00 none, 01 byte, 10 half, 11 word)
//   mem_write     write size (same encoding)
//   mem_unsigned  1 = zero-extend byte/half loads, 0 = sign-extend
//   address       byte address; bits at and above ADDR_WIDTH are ignored
//   write_data    store data; byte uses [7:0], half uses [15:0]
//   read_data     load result, held until the next load completes
//   rvalid        one-cycle pulse, read_data valid
//   wdone         one-cycle pulse, write committed
//   mem_stall     hold EX-MEM and everything upstream
//   access_error  one-cycle pulse for a rejected request
//
// Parameters:
//   ADDR_WIDTH    byte-address bits decoded (RAM = 2^ADDR_WIDTH bytes)
//   LATENCY       cycles from acceptance to completion, 1..15
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; an accepted one stalls combinationally
// BUSY  | access outstanding, down-counter running, mem_stall high
// DONE  | one cycle, result/commit pulse, inputs ignored
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic        mem_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rvalid,
  output logic        wdone,
  output logic        mem_stall,
  output logic        access_error
);

  localparam int WORDS = 1 << (ADDR_WIDTH - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            counter;

  // Request captured at acceptance; the pipeline may change its outputs
  // while we are busy, so only these copies are used afterwards.
  logic                  cap_write;
  logic [1:0]            cap_size;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_wdata;
  logic                  cap_unsigned;

  logic [31:0]           ram [0:WORDS-1];

  // Upper address bits are deliberately dropped so addresses wrap.
  logic                  addr_unused;
  assign addr_unused = ^address[31:ADDR_WIDTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic       rd_req;
  logic       wr_req;
  logic       req_valid;
  logic       req_conflict;
  logic [1:0] req_size;
  logic       misaligned;
  logic       accept;
  logic       reject;

  always_comb begin
    rd_req       = (mem_read != 2'b00);
    wr_req       = (mem_write != 2'b00);
    req_valid    = rd_req ^ wr_req;
    req_conflict = rd_req & wr_req;
    req_size     = rd_req ? mem_read : mem_write;
    misaligned   = ((req_size == SZ_HALF) && address[0]) ||
                   ((req_size == 2'b11) && (address[1:0] != 2'b00));
    accept       = !reset && (state == ST_IDLE) && req_valid && !misaligned;
    reject       = (state == ST_IDLE) && (req_conflict || (req_valid && misaligned));
  end

  // Stall is combinational on acceptance so the pipeline freezes in the
  // request cycle itself; reset kills it immediately.
  assign mem_stall = accept || (!reset && (state == ST_BUSY));

  // ---------------------------------------------------------------------------
  // Access source: with LATENCY=1 the access happens on the acceptance edge,
  // so the live inputs are used; otherwise the captured copies.
  // ---------------------------------------------------------------------------
  logic                  acc_write;
  logic [1:0]            acc_size;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_unsigned;
  logic                  do_access;

  always_comb begin
    if (state == ST_IDLE) begin
      acc_write    = wr_req;
      acc_size     = req_size;
      acc_addr     = address[ADDR_WIDTH-1:0];
      acc_wdata    = write_data;
      acc_unsigned = mem_unsigned;
    end else begin
      acc_write    = cap_write;
      acc_size     = cap_size;
      acc_addr     = cap_addr;
      acc_wdata    = cap_wdata;
      acc_unsigned = cap_unsigned;
    end
    // The access happens on the edge where the down-counter reaches zero.
    do_access = (accept && (CNT_LOAD == 4'd0)) ||
                (!reset && (state == ST_BUSY) && (counter == 4'd1));
  end

  // ---------------------------------------------------------------------------
  // Lane steering and load extension
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [3:0]            lane_en;
  logic [31:0]           lane_data;
  logic [31:0]           ram_word;
  logic [31:0]           byte_shift;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_val;

  always_comb begin
    word_idx = acc_addr[ADDR_WIDTH-1:2];
    ram_word = ram[word_idx];

    case (acc_size)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = acc_wdata;
      end
    endcase

    byte_shift = ram_word >> {acc_addr[1:0], 3'b000};
    load_byte  = byte_shift[7:0];
    load_half  = acc_addr[1] ? ram_word[31:16] : ram_word[15:0];

    case (acc_size)
      SZ_BYTE: load_val = {{24{load_byte[7] & !acc_unsigned}}, load_byte};
      SZ_HALF: load_val = {{16{load_half[15] & !acc_unsigned}}, load_half};
      default: load_val = ram_word;
    endcase
  end

  // RAM contents survive reset; a write dropped by reset never reaches here
  // because do_access is gated off.
  always_ff @(posedge clk) begin
    if (do_access && acc_write) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          ram[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      counter      <= 4'd0;
      cap_write    <= 1'b0;
      cap_size     <= 2'b00;
      cap_addr     <= '0;
      cap_wdata    <= 32'd0;
      cap_unsigned <= 1'b0;
      read_data    <= 32'd0;
      rvalid       <= 1'b0;
      wdone        <= 1'b0;
      access_error <= 1'b0;
    end else begin
      rvalid       <= do_access && !acc_write;
      wdone        <= do_access && acc_write;
      access_error <= reject;

      if (do_access && !acc_write) begin
        read_data <= load_val;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_write    <= wr_req;
            cap_size     <= req_size;
            cap_addr     <= address[ADDR_WIDTH-1:0];
            cap_wdata    <= write_data;
            cap_unsigned <= mem_unsigned;
            counter      <= CNT_LOAD;
            state        <= (CNT_LOAD == 4'd0) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Three responders (LATENCY 2, 1, 5) share address/data/unsigned inputs but
// each has its own mem_read/mem_write, so only the addressed one sees a
// request. A byte-array model of each RAM plus the held read_data value
// provides every expected result.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int AW = 10;

  logic        clk;
  logic        reset;
  logic [1:0]  mr [3];
  logic [1:0]  mw [3];
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd [3];
  logic        rv [3];
  logic        wd [3];
  logic        st [3];
  logic        er [3];

  logic [7:0]  mem_m [3][1024];
  logic [31:0] rd_m [3];

  int chk_cnt;
  int pass_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .mem_read(mr[0]), .mem_write(mw[0]),
    .mem_unsigned(uns), .address(addr), .write_data(wdata),
    .read_data(rd[0]), .rvalid(rv[0]), .wdone(wd[0]), .mem_stall(st[0]),
    .access_error(er[0])
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .mem_read(mr[1]), .mem_write(mw[1]),
    .mem_unsigned(uns), .address(addr), .write_data(wdata),
    .read_data(rd[1]), .rvalid(rv[1]), .wdone(wd[1]), .mem_stall(st[1]),
    .access_error(er[1])
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .mem_read(mr[2]), .mem_write(mw[2]),
    .mem_unsigned(uns), .address(addr), .write_data(wdata),
    .read_data(rd[2]), .rvalid(rv[2]), .wdone(wd[2]), .mem_stall(st[2]),
    .access_error(er[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 5;
  endfunction

  function automatic int nb_of(input logic [1:0] sz);
    return (sz == 2'd3) ? 4 : (sz == 2'd2) ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [1:0] sz,
                                             input logic u, input logic [31:0] a);
    int          b;
    int          nb;
    logic [31:0] v;
    b  = int'(a % 1024);
    nb = nb_of(sz);
    v  = 32'd0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[d][b + k];
    if (nb == 1 && !u && v[7])  v[31:8]  = 24'hFFFFFF;
    if (nb == 2 && !u && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic model_store(input int d, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] v);
    int b;
    b = int'(a % 1024);
    for (int k = 0; k < nb_of(sz); k++) mem_m[d][b + k] = v[8*k +: 8];
  endtask

  // One pipeline transaction: request is held until mem_stall drops (the
  // DONE cycle), then removed. Other inputs are scrambled while stalled.
  task automatic req(input int d, input logic [1:0] rs, input logic [1:0] ws,
                     input logic u, input logic [31:0] a, input logic [31:0] wv,
                     input string tag);
    logic       is_rd;
    logic [1:0] sz;
    logic       rej;
    int         stalls;
    is_rd = (rs != 2'd0);
    sz    = is_rd ? rs : ws;
    rej   = (rs != 2'd0 && ws != 2'd0) || ((a % nb_of(sz)) != 0);

    @(negedge clk);
    mr[d] = rs; mw[d] = ws; uns = u; addr = a; wdata = wv;
    #1;
    stalls = 0;
    while (st[d] === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      addr = $urandom; wdata = $urandom; uns = ~uns;
      #1;
    end
    chk({tag, ":stall_len"}, 32'(stalls), rej ? 32'd0 : 32'(lat_of(d)));

    if (!rej) begin
      if (is_rd) rd_m[d] = model_load(d, sz, u, a);
      else       model_store(d, sz, a, wv);
    end
    chk({tag, ":rvalid"}, 32'(rv[d]), 32'(!rej && is_rd));
    chk({tag, ":wdone"},  32'(wd[d]), 32'(!rej && !is_rd));
    chk({tag, ":rdata"},  rd[d], rd_m[d]);

    @(negedge clk);
    mr[d] = 2'd0; mw[d] = 2'd0;
    #1;
    chk({tag, ":err"},  32'(er[d]), 32'(rej));
    chk({tag, ":post"}, {29'd0, rv[d], wd[d], st[d]}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    reset = 1'b1; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int d = 0; d < 3; d++) begin
      mr[d] = 2'd0; mw[d] = 2'd0; rd_m[d] = 32'd0;
    end

    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_rdata", rd[d], 32'd0);
      chk("reset_flags", {28'd0, rv[d], wd[d], st[d], er[d]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Word write/read
    req(0, 2'd0, 2'd3, 1'b0, 32'h010, 32'hDEADBEEF, "t1_wr");
    req(0, 2'd3, 2'd0, 1'b0, 32'h010, 32'h0, "t1_rd");
    chk("t1_const", rd[0], 32'hDEADBEEF);

    // Byte writes and extension
    req(0, 2'd0, 2'd3, 1'b0, 32'h020, 32'h0, "t2_wr0");
    req(0, 2'd0, 2'd1, 1'b0, 32'h021, 32'hFFFFFF80, "t2_b80");
    req(0, 2'd0, 2'd1, 1'b0, 32'h022, 32'h1234567F, "t2_b7f");
    req(0, 2'd3, 2'd0, 1'b0, 32'h020, 32'h0, "t2_rdw");
    chk("t2_word_const", rd[0], 32'h007F8000);
    req(0, 2'd1, 2'd0, 1'b0, 32'h021, 32'h0, "t2_rdbs");
    chk("t2_sbyte_const", rd[0], 32'hFFFFFF80);
    req(0, 2'd1, 2'd0, 1'b1, 32'h021, 32'h0, "t2_rdbu");
    chk("t2_ubyte_const", rd[0], 32'h00000080);

    // Halfword
    req(0, 2'd0, 2'd3, 1'b0, 32'h030, 32'h12348765, "t3_wr");
    req(0, 2'd2, 2'd0, 1'b0, 32'h030, 32'h0, "t3_h0");
    chk("t3_h0_const", rd[0], 32'hFFFF8765);
    req(0, 2'd2, 2'd0, 1'b0, 32'h032, 32'h0, "t3_h1");
    chk("t3_h1_const", rd[0], 32'h00001234);
    req(0, 2'd0, 2'd2, 1'b0, 32'h032, 32'h5555AAAA, "t3_hw");
    req(0, 2'd3, 2'd0, 1'b0, 32'h030, 32'h0, "t3_rdw");
    chk("t3_word_const", rd[0], 32'hAAAA8765);

    // Rejected requests
    req(0, 2'd3, 2'd0, 1'b0, 32'h031, 32'h0, "t4_misal");
    chk("t4_hold_const", rd[0], 32'hAAAA8765);
    req(0, 2'd3, 2'd3, 1'b0, 32'h030, 32'h0, "t4_both");
    req(0, 2'd3, 2'd0, 1'b0, 32'h030, 32'h0, "t4_rdback");
    chk("t4_rdback_const", rd[0], 32'hAAAA8765);

    // Reset in the first BUSY cycle of a write
    req(0, 2'd0, 2'd3, 1'b0, 32'h040, 32'h11111111, "t5_init");
    @(negedge clk);
    mw[0] = 2'd3; addr = 32'h040; wdata = 32'h55555555;
    #1;
    chk("t5_stall_req", 32'(st[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("t5_stall_busy", 32'(st[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_stall_async", 32'(st[0]), 32'd0);
    mw[0] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t5_no_wdone", {30'd0, wd[0], st[0]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) rd_m[d] = 32'd0;
    chk("t5_rdata_reset", rd[0], 32'd0);
    req(0, 2'd3, 2'd0, 1'b0, 32'h040, 32'h0, "t5_rdback");
    chk("t5_rdback_const", rd[0], 32'h11111111);

    // Latency sweep and aliasing
    for (int d = 1; d < 3; d++) begin
      req(d, 2'd0, 2'd3, 1'b0, 32'h010, 32'hDEADBEEF, "t6_wr");
      req(d, 2'd3, 2'd0, 1'b0, 32'h010, 32'h0, "t6_rd");
      chk("t6_rd_const", rd[d], 32'hDEADBEEF);
    end
    req(0, 2'd0, 2'd3, 1'b0, 32'h410, 32'hCAFEF00D, "t6_alias_wr");
    req(0, 2'd3, 2'd0, 1'b0, 32'h010, 32'h0, "t6_alias_rd");
    chk("t6_alias_const", rd[0], 32'hCAFEF00D);

    // Randomized traffic on a preloaded window
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        req(d, 2'd0, 2'd3, 1'b0, 32'h100 + 32'(4 * w), $urandom, "rinit");
      end
      for (int n = 0; n < 40; n++) begin
        int          kind;
        int          nb;
        logic [1:0]  sz;
        logic [1:0]  rs;
        logic [1:0]  ws;
        logic [31:0] a;
        kind = int'($urandom_range(0, 9));
        sz   = 2'($urandom_range(1, 3));
        nb   = nb_of(sz);
        a    = 32'h100 + 32'($urandom_range(0, 63));
        if (kind < 8) a = a & ~32'(nb - 1);
        a = a | ($urandom << AW);
        if (kind == 9) begin
          rs = sz; ws = 2'($urandom_range(1, 3));
        end else if ($urandom_range(0, 1) == 0) begin
          rs = sz; ws = 2'd0;
        end else begin
          rs = 2'd0; ws = sz;
        end
        req(d, rs, ws, 1'($urandom_range(0, 1)), a, $urandom, "rand");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
